// File: rtl/uart_rx_config_cmd.sv
// uart_rx_config_cmd: UART receiver (8N1, or 8E1 when UART_RX_CMD_PARITY_EN is defined) and
// {0xA5, idx, val, chk} frame parser that writes one byte of the live motor config bus busNow.
module uart_rx_config_cmd #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 50000,
    parameter int BUS_W        = 32
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             uRx,
    input  logic [BUS_W-1:0] busDefault,
    output logic [BUS_W-1:0] busNow,
    output logic             cmdOk,
    output logic             frameErr,
    output logic             chkErr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CLKS);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_t;
    typedef enum logic [1:0] {P_SYNC, P_IDX, P_VAL, P_CHK} pState_t;
    rxState_t rxState, rxNext;
    pState_t pState, pNext;
    logic rxMeta, rxSync, rxPrev;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0] bitCnt, bitNext;
    logic [7:0] shReg, shNext, idx, idxNext, val, valNext;
    logic byteVld, badFrame, ldDef, okNext, chkNext;
    logic [TW-1:0] tCnt;
    logic [BUS_W-1:0] busNext;
`ifdef UART_RX_CMD_PARITY_EN
    logic parErr, parErrNext;
`endif
    // receiver state register, input synchroniser and frame error pulse
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rxMeta   <= 1'b1;
            rxSync   <= 1'b1;
            rxPrev   <= 1'b1;
            rxState  <= IDLE;
            cnt      <= '0;
            bitCnt   <= '0;
            shReg    <= '0;
            frameErr <= 1'b0;
`ifdef UART_RX_CMD_PARITY_EN
            parErr   <= 1'b0;
`endif
        end else begin
            rxMeta   <= uRx;
            rxSync   <= rxMeta;
            rxPrev   <= rxSync;
            rxState  <= rxNext;
            cnt      <= cntNext;
            bitCnt   <= bitNext;
            shReg    <= shNext;
            frameErr <= badFrame;
`ifdef UART_RX_CMD_PARITY_EN
            parErr   <= parErrNext;
`endif
        end
    end
    // receiver next state: mid-bit sampling, byteVld on good stop, badFrame otherwise
    always_comb begin
        rxNext   = rxState;
        cntNext  = cnt + 1'b1;
        bitNext  = bitCnt;
        shNext   = shReg;
        byteVld  = 1'b0;
        badFrame = 1'b0;
`ifdef UART_RX_CMD_PARITY_EN
        parErrNext = parErr;
`endif
        case (rxState)
            IDLE: begin
                cntNext = '0;
                if (rxPrev && !rxSync) rxNext = START;
            end
            START: if (cnt == HALF_END) begin
                cntNext = '0;
                bitNext = '0;
                rxNext  = rxSync ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_END) begin
                cntNext = '0;
                shNext  = {rxSync, shReg[7:1]};
                bitNext = bitCnt + 1'b1;
                if (bitCnt == 3'd7) begin
`ifdef UART_RX_CMD_PARITY_EN
                    rxNext = PARITY;
`else
                    rxNext = STOP;
`endif
                end
            end
`ifdef UART_RX_CMD_PARITY_EN
            PARITY: if (cnt == BIT_END) begin
                cntNext    = '0;
                parErrNext = rxSync != ^shReg;
                rxNext     = STOP;
            end
`endif
            STOP: if (cnt == BIT_END) begin
                rxNext = IDLE;
`ifdef UART_RX_CMD_PARITY_EN
                byteVld = rxSync && !parErr;
`else
                byteVld = rxSync;
`endif
                badFrame = !byteVld;
            end
            default: rxNext = IDLE;
        endcase
    end
    // parser state, config register, result pulses and inter-byte timeout counter
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pState <= P_SYNC;
            idx    <= '0;
            val    <= '0;
            busNow <= '0;
            cmdOk  <= 1'b0;
            chkErr <= 1'b0;
            ldDef  <= 1'b1;
            tCnt   <= '0;
        end else begin
            pState <= pNext;
            idx    <= idxNext;
            val    <= valNext;
            busNow <= busNext;
            cmdOk  <= okNext;
            chkErr <= chkNext;
            ldDef  <= 1'b0;
            tCnt   <= byteVld ? '0 : (tCnt == TMO_END ? tCnt : tCnt + 1'b1);
        end
    end
    // parser next state: a bad frame always resyncs; 0xA5 is only a header in P_SYNC
    always_comb begin
        pNext   = pState;
        idxNext = idx;
        valNext = val;
        busNext = busNow;
        okNext  = 1'b0;
        chkNext = 1'b0;
        if (ldDef) begin
            busNext = busDefault;
        end else if (badFrame) begin
            pNext = P_SYNC;
        end else if (byteVld) begin
            case (pState)
                P_SYNC: if (shReg == 8'hA5) pNext = P_IDX;
                P_IDX: begin
                    idxNext = shReg;
                    pNext   = P_VAL;
                end
                P_VAL: begin
                    valNext = shReg;
                    pNext   = P_CHK;
                end
                default: begin
                    pNext = P_SYNC;
                    if (shReg == (idx ^ val) && idx <= 8'd3) begin
                        busNext[{idx[1:0], 3'b000} +: 8] = val;
                        okNext = 1'b1;
                    end else if (shReg == (idx ^ val) && idx == 8'hFF) begin
                        busNext = busDefault;
                        okNext  = 1'b1;
                    end else begin
                        chkNext = 1'b1;
                    end
                end
            endcase
        end else if (pState != P_SYNC && tCnt == TMO_END) begin
            pNext = P_SYNC;
        end
    end
endmodule
